// File: rtl/step_period_meter.sv
// Measures the spacing of step edges in clk cycles and keeps a signed step position.
// Periods that exceed the counter range are reported as a stall and not measured.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | disabled or no step seen yet; cnt held at 0
// S_ARMED | one step seen; the interval now running is the first one
// S_TRACK | measuring; every step edge publishes N
// S_STALL | counter saturated without a step; next interval is discarded
module step_period_meter #(
    parameter int PERIOD_W = 17,
    parameter int POS_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                drv_step,
    input  logic                drv_dir,
    input  logic                enable,
    input  logic                clr,
    output logic [PERIOD_W-1:0] N,
    output logic                N_valid,
    output logic [POS_W-1:0]    position,
    output logic                stalled
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRACK = 2'd2,
        S_STALL = 2'd3
    } state_t;

    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic [PERIOD_W-1:0] r_n;
    logic [PERIOD_W-1:0] w_n_nxt;
    logic                r_n_valid;
    logic                w_n_valid_nxt;
    logic                r_stalled;
    logic                w_stalled_nxt;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    w_pos_nxt;
    logic                r_step_d;
    logic                r_live;
    logic                w_edge;
    logic                w_cnt_max;

    // r_live masks the first cycle after reset so a level already high is not an edge
    assign w_edge    = r_live & drv_step & ~r_step_d;
    assign w_cnt_max = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_edge) w_state_nxt = S_ARMED;
                end
                S_ARMED, S_TRACK: begin
                    if (w_edge)         w_state_nxt = S_TRACK;
                    else if (w_cnt_max) w_state_nxt = S_STALL;
                end
                S_STALL: begin
                    if (w_edge) w_state_nxt = S_ARMED;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_n_nxt       = r_n;
        w_n_valid_nxt = 1'b0;
        w_stalled_nxt = r_stalled;
        if (!enable) begin
            w_cnt_nxt     = '0;
            w_stalled_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt     = w_edge ? PERIOD_W'(1) : '0;
                    w_stalled_nxt = 1'b0;
                end
                S_ARMED, S_TRACK: begin
                    if (w_edge) begin
                        w_n_nxt       = r_cnt;
                        w_n_valid_nxt = 1'b1;
                        w_cnt_nxt     = PERIOD_W'(1);
                    end else if (w_cnt_max) begin
                        w_stalled_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + PERIOD_W'(1);
                    end
                end
                S_STALL: begin
                    if (w_edge) begin
                        w_cnt_nxt     = PERIOD_W'(1);
                        w_stalled_nxt = 1'b0;
                    end
                end
                default: w_cnt_nxt = '0;
            endcase
        end
    end

    always_comb begin
        w_pos_nxt = r_pos;
        if (clr) begin
            w_pos_nxt = '0;
        end else if (enable && w_edge) begin
            w_pos_nxt = drv_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_n       <= '0;
            r_n_valid <= 1'b0;
            r_stalled <= 1'b0;
            r_pos     <= '0;
            r_step_d  <= 1'b0;
            r_live    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_n       <= w_n_nxt;
            r_n_valid <= w_n_valid_nxt;
            r_stalled <= w_stalled_nxt;
            r_pos     <= w_pos_nxt;
            r_step_d  <= drv_step;
            r_live    <= 1'b1;
        end
    end

    assign N        = r_n;
    assign N_valid  = r_n_valid;
    assign position = r_pos;
    assign stalled  = r_stalled;

endmodule

// File: doc/step_period_meter.md
STEP_PERIOD_METER -- requirements
Module: step_period_meter

Interface
REQ-001 Parameter PERIOD_W, default 17, width of the measured-period output N; matches the period bus driving the step generator.
REQ-002 Parameter POS_W, default 32, width of the signed step-position accumulator.
REQ-003 clk  input  1  system clock (50 MHz); all logic synchronous to its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 drv_step  input  1  step pulse stream from the step generator, synchronous to clk.
REQ-006 drv_dir  input  1  direction; 1 = count up, 0 = count down; sampled with each step edge.
REQ-007 enable  input  1  measurement enable; 0 forces IDLE.
REQ-008 clr  input  1  synchronous clear of position; single-cycle strobe.
REQ-009 N  output  PERIOD_W  last measured step period, in clk cycles.
REQ-010 N_valid  output  1  one-cycle strobe, high in the cycle N is updated.
REQ-011 position  output  POS_W  signed step count, two's complement.
REQ-012 stalled  output  1  high while no step has arrived within the maximum measurable period.

Function
REQ-013 Step edge SHALL be drv_step==1 with the registered previous drv_step==0; a high level lasting several cycles counts as one step.
REQ-014 The period counter cnt (PERIOD_W bits) SHALL load 1 on a step edge; otherwise it SHALL increment, saturating at 2^PERIOD_W-1.
REQ-015 The FSM SHALL have states IDLE, ARMED, TRACK, STALL.
REQ-016 IDLE: cnt held at 0; on a step edge with enable=1 -> ARMED, cnt<=1, no N update.
REQ-017 ARMED/TRACK: on a step edge, N<=cnt and N_valid<=1 at that same clock edge, cnt<=1, next state TRACK.
REQ-018 ARMED/TRACK: when cnt reaches 2^PERIOD_W-1 with no step edge -> STALL, stalled<=1; N keeps its last value.
REQ-019 STALL: on a step edge -> ARMED, stalled<=0, cnt<=1, no N update (first interval after a stall is discarded).
REQ-020 enable=0 in any state: next state IDLE, stalled<=0, N_valid<=0; N and position retained.
REQ-021 Steps spaced P cycles apart (edges sampled at posedges t and t+P) SHALL yield N=P; minimum measurable P = 2.
REQ-022 position SHALL increment (drv_dir=1) or decrement (drv_dir=0) by 1 on every step edge while enable=1, in any state including IDLE, using drv_dir sampled in the edge cycle.
REQ-023 position SHALL wrap modulo 2^POS_W without a flag.
REQ-024 clr=1 SHALL set position to 0; clr concurrent with a step edge: clr wins, position=0.
REQ-025 N_valid SHALL be high for exactly one cycle per measurement, never two consecutive cycles.

Reset
REQ-026 rst=0 SHALL asynchronously force: state IDLE, cnt=0, N=0, N_valid=0, position=0, stalled=0, previous-step register=0.
REQ-027 Release of rst SHALL take effect at the next clk edge; a drv_step already high at release SHALL NOT count as an edge.
REQ-028 Reset asserted mid-measurement SHALL discard the partial interval; no N_valid is produced for it.

Verification
REQ-029 enable=1, drv_step high 1 cycle every 5 cycles, drv_dir=1, 10 pulses -> first pulse: no N_valid; pulses 2..10: N=5, N_valid strobes 9 times; position=10.
REQ-030 Period change from 5 to 8 cycles, drv_dir=0 -> first 8-cycle interval gives N=8 on the next edge; position decreases by 1 per pulse.
REQ-031 PERIOD_W=4, pulses stop -> stalled=1 once cnt=15; N unchanged; next pulse -> stalled=0, no N_valid; following pulse 6 cycles later -> N=6.
REQ-032 drv_step held high 7 cycles, then low 3, repeated -> one count per pulse; N=10.
REQ-033 clr in the same cycle as a step edge at position=3 -> position=0; next edge (drv_dir=1) -> position=1.
REQ-034 rst=0 for 3 cycles mid-interval with drv_step high at release -> all outputs 0; no step counted until drv_step goes low then high.
